ifu_fetch: RTL and testbench

Instruction fetch unit that sits directly upstream of the npc decode/execute core and replaces its combinational instruction read.
- Owns the architectural PC and issues one 32-bit fetch per instruction over a valid/ready request / valid response memory port.
- Presents the fetched word to the core with a valid/ready handshake.
- Waits for the core's retire report carrying the next PC before fetching again; there is no speculation.

---
 rtl/ifu_fetch.sv | 132 +++++++++++++
 tb/tb_ifu_fetch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction and hands it to the core.
// Optional misaligned-PC fault reporting is enabled by defining IFU_ALIGN_CHECK_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h80000000,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_fault,
    input  logic        wb_valid,
    input  logic [31:0] wb_next_pc,
    output logic [31:0] pc,
    output logic [1:0]  o_dbg_state
);

    // Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready;
    // an instruction transfers on inst_valid && inst_ready. imem_rsp_valid and wb_valid
    // are single-cycle strobes with no back-pressure.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_inst;
    logic [31:0]      r_inst_pc;
    logic [1:0]       r_fault;
    logic             r_inst_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_next_pc;
    logic             w_misaligned;
    logic             w_timeout;

`ifdef IFU_ALIGN_CHECK_EN
    assign w_next_pc    = wb_next_pc;
    assign w_misaligned = (r_pc[1:0] != 2'b00);
`else
    assign w_next_pc    = wb_next_pc & ~32'h3;
    assign w_misaligned = 1'b0;
`endif

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    assign imem_req_valid = !reset && (r_state == S_REQ) && !w_misaligned;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign inst_fault     = r_fault;
    assign pc             = r_pc;
    assign o_dbg_state    = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_inst_pc    <= 32'h0;
            r_fault      <= 2'd0;
            r_inst_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_misaligned) begin
                        r_inst       <= 32'h0;
                        r_inst_pc    <= r_pc;
                        r_fault      <= 2'd3;
                        r_inst_valid <= 1'b1;
                        r_state      <= S_OUT;
                    end else if (imem_req_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A response in the final timeout cycle still wins.
                    if (imem_rsp_valid) begin
                        r_inst       <= imem_rsp_err ? 32'h0 : imem_rsp_data;
                        r_inst_pc    <= r_pc;
                        r_fault      <= imem_rsp_err ? 2'd1 : 2'd0;
                        r_inst_valid <= 1'b1;
                        r_state      <= S_OUT;
                    end else if (w_timeout) begin
                        r_inst       <= 32'h0;
                        r_inst_pc    <= r_pc;
                        r_fault      <= 2'd2;
                        r_inst_valid <= 1'b1;
                        r_state      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        if (wb_valid) begin
                            r_pc    <= w_next_pc;
                            r_state <= S_REQ;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (wb_valid) begin
                        r_pc    <= w_next_pc;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: drivers push hand-computed expectations, a negedge monitor
// pops and compares on every request and instruction handshake.
module tb_ifu_fetch;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        imem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_fault;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_next_pc = 32'h0;
    logic [31:0] pc;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] req_q[$];
    logic [65:0] exp_q[$];

    ifu_fetch #(
        .RESET_PC(32'h80000000),
        .TIMEOUT_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_fault(inst_fault),
        .wb_valid(wb_valid),
        .wb_next_pc(wb_next_pc),
        .pc(pc),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req_valid && imem_req_ready) begin
                if (req_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_unexpected: got request at %h, expected none", imem_req_addr);
                end else begin
                    chk("req_addr", imem_req_addr, req_q.pop_front());
                end
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL inst_unexpected: got inst %h pc %h, expected none", inst, inst_pc);
                end else begin
                    logic [65:0] e;
                    e = exp_q.pop_front();
                    chk("inst", inst, e[65:34]);
                    chk("inst_pc", inst_pc, e[33:2]);
                    chk("inst_fault", {30'h0, inst_fault}, {30'h0, e[1:0]});
                end
            end
        end
    end

    // drivers
    task automatic push_inst(input logic [31:0] d, input logic [31:0] a, input logic [1:0] f);
        exp_q.push_back({d, a, f});
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("req_wait_bound", {31'h0, imem_req_valid}, 32'h1);
    endtask

    task automatic wait_inst();
        int n = 0;
        while (!inst_valid && n < 20) begin
            step();
            n++;
        end
        chk("inst_wait_bound", {31'h0, inst_valid}, 32'h1);
    endtask

    // rsp_lat == 0 means no response: expect the 4-cycle timeout.
    task automatic issue_fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                               input int rdy_wait, input int rsp_lat);
        req_q.push_back(addr);
        wait_req();
        for (int i = 0; i < rdy_wait; i++) begin
            chk("req_hold_valid", {31'h0, imem_req_valid}, 32'h1);
            chk("req_hold_addr", imem_req_addr, addr);
            step();
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        if (rsp_lat == 0) begin
            repeat (3) step();
            chk("timeout_early", {31'h0, inst_valid}, 32'h0);
            step();
            chk("timeout_latency", {31'h0, inst_valid}, 32'h1);
        end else begin
            repeat (rsp_lat - 1) step();
            chk("rsp_early", {31'h0, inst_valid}, 32'h0);
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data;
            imem_rsp_err   = err;
            step();
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            chk("rsp_latency", {31'h0, inst_valid}, 32'h1);
        end
    endtask

    task automatic take_retire(input logic [31:0] next_pc);
        wait_inst();
        inst_ready = 1'b1;
        wb_valid   = 1'b1;
        wb_next_pc = next_pc;
        step();
        inst_ready = 1'b0;
        wb_valid   = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("reset_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("reset_pc", pc, 32'h80000000);
        chk("reset_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("reset_inst", inst, 32'h0);
        chk("reset_inst_pc", inst_pc, 32'h0);
        chk("reset_fault", {30'h0, inst_fault}, 32'h0);
        chk("reset_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
        reset = 1'b0;

        // basic fetch, then hold with inst_ready low and a stray response
        push_inst(32'h00100093, 32'h80000000, 2'd0);
        issue_fetch(32'h80000000, 32'h00100093, 1'b0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hdeadbeef;
            end
            step();
            imem_rsp_valid = 1'b0;
            chk("hold_valid", {31'h0, inst_valid}, 32'h1);
            chk("hold_inst", inst, 32'h00100093);
            chk("hold_inst_pc", inst_pc, 32'h80000000);
            chk("hold_no_req", {31'h0, imem_req_valid}, 32'h0);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("exec_state", {30'h0, dbg_state}, {30'h0, ST_EXEC});
        chk("exec_inst_valid", {31'h0, inst_valid}, 32'h0);
        wb_valid   = 1'b1;
        wb_next_pc = 32'h80000004;
        step();
        wb_valid = 1'b0;
        chk("retire_req_addr", imem_req_addr, 32'h80000004);

        // 2-cycle response, then same-cycle jal retire
        push_inst(32'h00000013, 32'h80000004, 2'd0);
        issue_fetch(32'h80000004, 32'h00000013, 1'b0, 0, 2);
        take_retire(32'h80000010);
        chk("jal_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
        chk("jal_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("jal_req_addr", imem_req_addr, 32'h80000010);

        // request back-pressure for 3 cycles
        push_inst(32'h12345678, 32'h80000010, 2'd0);
        issue_fetch(32'h80000010, 32'h12345678, 1'b0, 3, 1);
        take_retire(32'h80000020);

        // timeout with no response
        push_inst(32'h00000000, 32'h80000020, 2'd2);
        issue_fetch(32'h80000020, 32'h0, 1'b0, 0, 0);
        take_retire(32'h80000024);

        // bus error arriving in the last timeout cycle: error beats timeout
        push_inst(32'h00000000, 32'h80000024, 2'd1);
        issue_fetch(32'h80000024, 32'hffffffff, 1'b1, 0, 4);
        take_retire(32'h80000006);

`ifdef IFU_ALIGN_CHECK_EN
        chk("misalign_pc", pc, 32'h80000006);
        chk("misalign_no_req", {31'h0, imem_req_valid}, 32'h0);
        push_inst(32'h00000000, 32'h80000006, 2'd3);
        step();
        chk("misalign_valid", {31'h0, inst_valid}, 32'h1);
        take_retire(32'h80000100);
`else
        chk("align_clear_addr", imem_req_addr, 32'h80000004);
        push_inst(32'h00200113, 32'h80000004, 2'd0);
        issue_fetch(32'h80000004, 32'h00200113, 1'b0, 0, 1);
        take_retire(32'h80000100);
`endif
        chk("pc_after_jump", pc, 32'h80000100);

        // reset while waiting for a response; the late response must be dropped
        req_q.push_back(32'h80000100);
        wait_req();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("wait_state", {30'h0, dbg_state}, {30'h0, ST_WAIT});
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_pc", pc, 32'h80000000);
        chk("midreset_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hcafef00d;
        step();
        imem_rsp_valid = 1'b0;
        chk("late_rsp_dropped", {31'h0, inst_valid}, 32'h0);
        chk("late_rsp_state", {30'h0, dbg_state}, {30'h0, ST_REQ});

        // recovery fetch from the reset PC
        push_inst(32'h00000073, 32'h80000000, 2'd0);
        issue_fetch(32'h80000000, 32'h00000073, 1'b0, 0, 1);
        take_retire(32'h80000004);
        repeat (3) step();
        chk("req_q_empty", req_q.size(), 32'h0);
        chk("exp_q_empty", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
